// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer
// Drives a character-LCD write engine. After power-up it writes the HD44780
// init list. Each refresh request then redraws both 16-character lines from an
// external synchronous text buffer. Every byte goes through the same handshake:
// ISSUE -> WAIT_ACK -> WAIT_IDLE. If the engine never acknowledges a strobe,
// the block latches err and parks in FAULT until reset.
//
// Ports
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   refresh      single-cycle redraw request
//   char_addr    text buffer address (0-15 line 1, 16-31 line 2)
//   char_data    buffer data, valid one cycle after char_addr
//   lcd_send     one-cycle write strobe
//   lcd_op       00 instruction, 01 data
//   lcd_cmd      byte to write, held from strobe until the next strobe
//   lcd_busy     write engine busy
//   lcd_ready    write engine idle and past power-up
//   init_done    init list written
//   update_busy  init or redraw in progress
//   err          sticky acknowledge-timeout flag
module lcd_text_sequencer #(
    parameter int ACK_TIMEOUT   = 16,
    parameter bit CLEAR_ON_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refresh,
    output logic [4:0] char_addr,
    input  logic [7:0] char_data,
    output logic       lcd_send,
    output logic [1:0] lcd_op,
    output logic [7:0] lcd_cmd,
    input  logic       lcd_busy,
    input  logic       lcd_ready,
    output logic       init_done,
    output logic       update_busy,
    output logic       err
);

    localparam logic [1:0] INIT_LAST = CLEAR_ON_INIT ? 2'd3 : 2'd2;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        PWR_WAIT, INIT, IDLE, ADDR1, TEXT1, ADDR2, TEXT2, FAULT
    } state_t;

    // Per-byte sub-sequence. PH_PREP waits for the engine to be free, so
    // PH_ISSUE is only ever entered with lcd_ready=1 and lcd_busy=0.
    typedef enum logic [2:0] {
        PH_PREP, PH_FETCH, PH_LATCH, PH_ISSUE, PH_WAIT_ACK, PH_WAIT_IDLE
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [1:0]    idx_q, idx_d;
    logic [4:0]    addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [1:0]    op_q, op_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pending_q, pending_d;
    logic          init_done_q, init_done_d;
    logic          err_q, err_d;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Non-printable codes would show as garbage glyphs; print a space instead.
    function automatic logic [7:0] sanitize(input logic [7:0] b);
        return ((b < 8'h20) || (b > 8'h7E)) ? 8'h20 : b;
    endfunction

    assign update_busy = (state_q != IDLE) && (state_q != FAULT);
    assign lcd_send    = (phase_q == PH_ISSUE) && (state_q != FAULT);
    assign lcd_op      = op_q;
    assign lcd_cmd     = cmd_q;
    assign char_addr   = addr_q;
    assign init_done   = init_done_q;
    assign err         = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PWR_WAIT;
            phase_q     <= PH_PREP;
            idx_q       <= 2'd0;
            addr_q      <= 5'd0;
            data_q      <= 8'h00;
            cmd_q       <= 8'h00;
            op_q        <= 2'b00;
            tmr_q       <= '0;
            pending_q   <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cmd_q       <= cmd_d;
            op_q        <= op_d;
            tmr_q       <= tmr_d;
            pending_q   <= pending_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        cmd_d       = cmd_q;
        op_d        = op_q;
        tmr_d       = tmr_q;
        pending_d   = pending_q;
        init_done_d = init_done_q;
        err_d       = err_q;

        // Requests arriving mid-update collapse into a single pending redraw.
        // This includes the TEXT2 -> IDLE edge cycle, which is still busy.
        if (refresh && update_busy) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            PWR_WAIT: begin
                if (lcd_ready) begin
                    state_d = INIT;
                    phase_d = PH_PREP;
                    idx_d   = 2'd0;
                end
            end
            IDLE: begin
                if (refresh || pending_q) begin
                    state_d   = ADDR1;
                    phase_d   = PH_PREP;
                    pending_d = 1'b0;
                end
            end
            FAULT: begin
            end
            default: begin
                case (phase_q)
                    PH_FETCH: phase_d = PH_LATCH;
                    PH_LATCH: begin
                        data_d  = sanitize(char_data);
                        phase_d = PH_PREP;
                    end
                    PH_PREP: begin
                        if (lcd_ready && !lcd_busy) begin
                            phase_d = PH_ISSUE;
                            op_d    = 2'b00;
                            case (state_q)
                                INIT:    cmd_d = init_byte(idx_q);
                                ADDR1:   cmd_d = 8'h80;
                                ADDR2:   cmd_d = 8'hC0;
                                default: begin
                                    cmd_d = data_q;
                                    op_d  = 2'b01;
                                end
                            endcase
                        end
                    end
                    PH_ISSUE: begin
                        phase_d = PH_WAIT_ACK;
                        tmr_d   = '0;
                    end
                    PH_WAIT_ACK: begin
                        if (lcd_busy) begin
                            phase_d = PH_WAIT_IDLE;
                        end else if (tmr_q == TMO_LAST) begin
                            err_d   = 1'b1;
                            state_d = FAULT;
                        end else begin
                            tmr_d = tmr_q + 1'b1;
                        end
                    end
                    PH_WAIT_IDLE: begin
                        if (!lcd_busy && lcd_ready) begin
                            phase_d = PH_PREP;
                            case (state_q)
                                INIT: begin
                                    if (idx_q == INIT_LAST) begin
                                        state_d     = IDLE;
                                        init_done_d = 1'b1;
                                    end else begin
                                        idx_d = idx_q + 2'd1;
                                    end
                                end
                                ADDR1: begin
                                    state_d = TEXT1;
                                    phase_d = PH_FETCH;
                                end
                                TEXT1: begin
                                    addr_d = addr_q + 5'd1;
                                    if (addr_q == 5'd15) state_d = ADDR2;
                                    else                 phase_d = PH_FETCH;
                                end
                                ADDR2: begin
                                    state_d = TEXT2;
                                    phase_d = PH_FETCH;
                                end
                                default: begin
                                    // TEXT2: 31 + 1 wraps back to 0 for the next redraw.
                                    addr_d = addr_q + 5'd1;
                                    if (addr_q == 5'd31) state_d = IDLE;
                                    else                 phase_d = PH_FETCH;
                                end
                            endcase
                        end
                    end
                    default: phase_d = PH_PREP;
                endcase
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed bench for lcd_text_sequencer. It includes a behavioural LCD write
// engine (ready 50 cycles after reset; busy from 3 cycles after each strobe
// for 10 cycles), a synchronous text buffer and a strobe recorder.
module tb_lcd_text_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       refresh = 1'b0;
    logic [4:0] char_addr;
    logic [7:0] char_data;
    logic       lcd_send;
    logic [1:0] lcd_op;
    logic [7:0] lcd_cmd;
    logic       lcd_busy;
    logic       lcd_ready;
    logic       init_done;
    logic       update_busy;
    logic       err;

    int checks = 0;
    int passes = 0;
    int viol = 0;
    bit no_ack = 1'b0;
    logic prev_send = 1'b0;
    int ready_cnt;
    int busy_cnt;
    logic [7:0] mem [32];
    logic [9:0] strobes [$];

    always #5 clk = ~clk;

    lcd_text_sequencer #(.ACK_TIMEOUT(16), .CLEAR_ON_INIT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .refresh(refresh),
        .char_addr(char_addr), .char_data(char_data),
        .lcd_send(lcd_send), .lcd_op(lcd_op), .lcd_cmd(lcd_cmd),
        .lcd_busy(lcd_busy), .lcd_ready(lcd_ready),
        .init_done(init_done), .update_busy(update_busy), .err(err)
    );

    always @(posedge clk) char_data <= mem[char_addr];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)            ready_cnt <= 0;
        else if (ready_cnt < 50) ready_cnt <= ready_cnt + 1;
    end
    assign lcd_ready = (ready_cnt >= 50);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         busy_cnt <= 0;
        else if (lcd_send && !no_ack)         busy_cnt <= 1;
        else if (busy_cnt != 0 && busy_cnt < 12) busy_cnt <= busy_cnt + 1;
        else                                  busy_cnt <= 0;
    end
    assign lcd_busy = (busy_cnt >= 3);

    always @(posedge clk) begin
        if (reset_n) begin
            if (lcd_send) begin
                strobes.push_back({lcd_op, lcd_cmd});
                if (prev_send || lcd_busy) viol <= viol + 1;
            end
            prev_send <= lcd_send;
        end else begin
            prev_send <= 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_refresh;
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic wait_init(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (init_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!update_busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_strobes(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (strobes.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        logic [18:0] obs;
        reset_n = 1'b0;
        cyc(3);
        obs = {lcd_send, lcd_op, lcd_cmd, char_addr, init_done, update_busy, err};
        checks++;
        if (obs !== {1'b0, 2'b00, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL reset_outputs got %h want %h", obs, {1'b0, 2'b00, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0});
        else passes++;
        $display("reset: outputs %h", obs);
    endtask

    task automatic test_init;
        bit ok;
        logic [9:0] exp [4];
        exp[0] = 10'h038; exp[1] = 10'h00C; exp[2] = 10'h006; exp[3] = 10'h001;
        reset_n = 1'b1;
        cyc(45);
        checks++;
        if (strobes.size() != 0 || update_busy !== 1'b1 || init_done !== 1'b0)
            $display("FAIL pwr_wait got strobes=%0d busy=%b done=%b want 0 1 0", strobes.size(), update_busy, init_done);
        else passes++;
        wait_init(ok);
        checks++;
        if (!ok) $display("FAIL init_timeout got init_done=%b want 1", init_done); else passes++;
        checks++;
        if (strobes.size() != 4) $display("FAIL init_count got %0d want 4", strobes.size()); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (strobes[i] !== exp[i]) $display("FAIL init_byte%0d got %h want %h", i, strobes[i], exp[i]);
            else passes++;
        end
        checks++;
        if (update_busy !== 1'b0) $display("FAIL init_idle got update_busy=%b want 0", update_busy); else passes++;
        $display("init: %0d strobes, init_done=%b", strobes.size(), init_done);
    endtask

    task automatic test_redraw;
        bit ok;
        string s1 = "COFFEE READY";
        string s2 = "CUP 1";
        logic [9:0] exp [34];
        for (int i = 0; i < 16; i++) begin
            mem[i]      = (i < s1.len()) ? s1[i] : 8'h20;
            mem[16 + i] = (i < s2.len()) ? s2[i] : 8'h20;
        end
        exp[0]  = 10'h080;
        exp[17] = 10'h0C0;
        for (int i = 0; i < 16; i++) begin
            exp[1 + i]  = {2'b01, mem[i]};
            exp[18 + i] = {2'b01, mem[16 + i]};
        end
        strobes.delete();
        pulse_refresh();
        wait_idle(ok);
        checks++;
        if (!ok) $display("FAIL redraw_timeout got update_busy=%b want 0", update_busy); else passes++;
        checks++;
        if (strobes.size() != 34) $display("FAIL redraw_count got %0d want 34", strobes.size()); else passes++;
        checks++;
        if (strobes[1] !== 10'h143) $display("FAIL redraw_first_char got %h want 143", strobes[1]); else passes++;
        for (int i = 0; i < 34; i++) begin
            checks++;
            if (strobes[i] !== exp[i]) $display("FAIL redraw_byte%0d got %h want %h", i, strobes[i], exp[i]);
            else passes++;
        end
        checks++;
        if (char_addr !== 5'd0) $display("FAIL redraw_addr_wrap got %0d want 0", char_addr); else passes++;
        $display("redraw: %0d strobes, update_busy=%b", strobes.size(), update_busy);
    endtask

    task automatic test_sanitize;
        bit ok;
        mem[5] = 8'h0A; mem[6] = 8'h1F; mem[7] = 8'h7E;
        mem[20] = 8'hFF; mem[21] = 8'h7F; mem[22] = 8'h21;
        strobes.delete();
        pulse_refresh();
        wait_idle(ok);
        checks++;
        if (!ok || strobes.size() != 34) $display("FAIL sanitize_count got %0d want 34", strobes.size()); else passes++;
        checks++;
        if (strobes[6] !== 10'h120) $display("FAIL sanitize_0A got %h want 120", strobes[6]); else passes++;
        checks++;
        if (strobes[7] !== 10'h120) $display("FAIL sanitize_1F got %h want 120", strobes[7]); else passes++;
        checks++;
        if (strobes[8] !== 10'h17E) $display("FAIL sanitize_7E got %h want 17E", strobes[8]); else passes++;
        checks++;
        if (strobes[22] !== 10'h120) $display("FAIL sanitize_FF got %h want 120", strobes[22]); else passes++;
        checks++;
        if (strobes[23] !== 10'h120) $display("FAIL sanitize_7F got %h want 120", strobes[23]); else passes++;
        checks++;
        if (strobes[24] !== 10'h121) $display("FAIL sanitize_21 got %h want 121", strobes[24]); else passes++;
        $display("sanitize: pos5=%h pos20=%h", strobes[6], strobes[22]);
    endtask

    task automatic test_pending;
        bit ok;
        strobes.delete();
        pulse_refresh();
        cyc(60);  pulse_refresh();
        cyc(20);  pulse_refresh();
        cyc(20);  pulse_refresh();
        wait_strobes(68, ok);
        checks++;
        if (!ok) $display("FAIL pending_timeout got %0d strobes want 68", strobes.size()); else passes++;
        wait_idle(ok);
        cyc(100);
        checks++;
        if (strobes.size() != 68 || update_busy !== 1'b0)
            $display("FAIL pending_count got %0d busy=%b want 68 0", strobes.size(), update_busy);
        else passes++;
        checks++;
        if (strobes[34] !== 10'h080) $display("FAIL pending_second_addr got %h want 080", strobes[34]); else passes++;
        $display("pending: %0d strobes", strobes.size());
    endtask

    task automatic test_back_to_back;
        bit ok;
        strobes.delete();
        pulse_refresh();
        wait_strobes(34, ok);
        for (int i = 0; i < 20 && !lcd_busy; i++) @(negedge clk);
        for (int i = 0; i < 20 && lcd_busy; i++) @(negedge clk);
        // This cycle is the TEXT2 -> IDLE transition.
        pulse_refresh();
        wait_strobes(68, ok);
        checks++;
        if (!ok) $display("FAIL b2b_timeout got %0d strobes want 68", strobes.size()); else passes++;
        wait_idle(ok);
        cyc(100);
        checks++;
        if (strobes.size() != 68) $display("FAIL b2b_count got %0d want 68", strobes.size()); else passes++;
        checks++;
        if (strobes[34] !== 10'h080) $display("FAIL b2b_second_addr got %h want 080", strobes[34]); else passes++;
        $display("back_to_back: %0d strobes", strobes.size());
    endtask

    task automatic test_timeout;
        bit seen = 1'b0;
        no_ack = 1'b1;
        pulse_refresh();
        for (int i = 0; i < 50; i++) begin
            if (lcd_send) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!seen) $display("FAIL timeout_no_send got lcd_send=0 want 1"); else passes++;
        cyc(16);
        checks++;
        if (err !== 1'b0 || update_busy !== 1'b1)
            $display("FAIL timeout_early got err=%b busy=%b want 0 1", err, update_busy);
        else passes++;
        cyc(1);
        checks++;
        if (err !== 1'b1 || update_busy !== 1'b0)
            $display("FAIL timeout_err got err=%b busy=%b want 1 0", err, update_busy);
        else passes++;
        strobes.delete();
        pulse_refresh();
        cyc(200);
        checks++;
        if (strobes.size() != 0 || err !== 1'b1 || update_busy !== 1'b0)
            $display("FAIL fault_terminal got strobes=%0d err=%b busy=%b want 0 1 0", strobes.size(), err, update_busy);
        else passes++;
        $display("timeout: err=%b strobes_after=%0d", err, strobes.size());
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit hit = 1'b0;
        logic [18:0] obs;
        no_ack = 1'b0;
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        wait_init(ok);
        strobes.delete();
        pulse_refresh();
        for (int i = 0; i < 2000; i++) begin
            if (char_addr == 5'd7) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) $display("FAIL midreset_addr7 got %0d want 7", char_addr); else passes++;
        #1 reset_n = 1'b0;
        #1 obs = {lcd_send, lcd_op, lcd_cmd, char_addr, init_done, update_busy, err};
        checks++;
        if (obs !== {1'b0, 2'b00, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL midreset_outputs got %h want %h", obs, {1'b0, 2'b00, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0});
        else passes++;
        cyc(3);
        strobes.delete();
        reset_n = 1'b1;
        wait_init(ok);
        checks++;
        if (!ok || strobes.size() != 4) $display("FAIL midreset_init got %0d strobes want 4", strobes.size()); else passes++;
        checks++;
        if (strobes[0] !== 10'h038 || strobes[3] !== 10'h001)
            $display("FAIL midreset_seq got %h..%h want 038..001", strobes[0], strobes[3]);
        else passes++;
        $display("reset_mid: %0d strobes after restart", strobes.size());
    endtask

    task automatic test_protocol;
        checks++;
        if (viol != 0) $display("FAIL strobe_protocol got %0d violations want 0", viol); else passes++;
        $display("protocol: %0d violations", viol);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h20;
        test_reset();
        test_init();
        test_redraw();
        test_sanitize();
        test_pending();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
